// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the two-master data bus arbiter: FSM encodings
// and master index constants.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/data_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin arbiter with a lock override that
// forces the DMA master to win a tie.
module rr_arb2
  import data_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] exclude,
  input  logic       last,
  input  logic       lock_win,
  output logic       valid,
  output logic       grant
);

  logic [1:0] elig;

  always_comb begin
    elig  = req & ~exclude;
    valid = |elig;
    grant = M_CPU;
    if (elig == 2'b11) begin
      grant = lock_win ? M_DMA : ~last;
    end else begin
      grant = elig[1];
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data-side bus between the CPU (master 0) and a DMA/boot master
// (master 1), running each access as a fixed-length transaction with an ack.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  input  logic        m1_lock,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  output state_t      dbg_state
);

  // Handshake: a master raises req with we/addr/wdata stable and holds them
  // until it sees a one-cycle ack; the request is consumed on that ack and a
  // req still high in the ack cycle is not treated as a new request (except
  // for a locking DMA master, which streams back-to-back accesses).

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  state_t        state, state_n;
  logic          gnt, gnt_n;
  logic [2:0]    wcnt, wcnt_n;
  logic          last_grant;
  logic [LW-1:0] lock_cnt;
  logic [31:0]   addr_q, wdata_q;
  logic          we_q;
  logic [31:0]   m0_rdata_q, m1_rdata_q;

  logic          lock_win;
  logic [1:0]    arb_exclude;
  logic          arb_valid, arb_grant;
  logic          take;
  logic          capture;

  assign lock_win = m1_lock && (lock_cnt < LOCK_MAX);

  // The acked master is excluded unless it is a DMA master still inside its lock budget.
  always_comb begin
    arb_exclude = 2'b00;
    if (state == ST_ACK) begin
      if (gnt == M_CPU) arb_exclude = 2'b01;
      else              arb_exclude = {~lock_win, 1'b0};
    end
  end

  rr_arb2 u_arb (
    .req      ({m1_req, m0_req}),
    .exclude  (arb_exclude),
    .last     (last_grant),
    .lock_win (lock_win),
    .valid    (arb_valid),
    .grant    (arb_grant)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    wcnt_n  = wcnt;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          state_n = ST_ACCESS;
          gnt_n   = arb_grant;
          take    = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (we_q || (RD_LATENCY == 1)) begin
          state_n = ST_ACK;
        end else begin
          state_n = ST_WAIT;
          wcnt_n  = 3'(RD_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        wcnt_n = wcnt - 3'd1;
        if (wcnt == 3'd1) state_n = ST_ACK;
      end
      ST_ACK: begin
        if (arb_valid) begin
          state_n = ST_ACCESS;
          gnt_n   = arb_grant;
          take    = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Read data is sampled on the edge that ends the final address/wait cycle.
  assign capture = ((state == ST_ACCESS) && !we_q && (RD_LATENCY == 1)) ||
                   ((state == ST_WAIT) && (wcnt == 3'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gnt        <= M_CPU;
      wcnt       <= 3'd0;
      last_grant <= M_DMA;
      lock_cnt   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      wcnt  <= wcnt_n;
      if (state == ST_ACK) last_grant <= gnt;
      if (take) begin
        addr_q  <= (arb_grant == M_DMA) ? m1_addr  : m0_addr;
        wdata_q <= (arb_grant == M_DMA) ? m1_wdata : m0_wdata;
        we_q    <= (arb_grant == M_DMA) ? m1_we    : m0_we;
      end
      if (!m1_lock) begin
        lock_cnt <= '0;
      end else if (take && (arb_grant == M_CPU)) begin
        lock_cnt <= '0;
      end else if (take && m0_req && (lock_cnt < LOCK_MAX)) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      if (capture) begin
        if (gnt == M_DMA) m1_rdata_q <= bus_rdata;
        else              m0_rdata_q <= bus_rdata;
      end
    end
  end

  assign bus_addr  = ((state == ST_ACCESS) || (state == ST_WAIT)) ? addr_q : '0;
  assign bus_wdata = (state == ST_ACCESS) ? wdata_q : '0;
  assign bus_we    = (state == ST_ACCESS) && we_q;
  assign bus_re    = (state == ST_ACCESS) && !we_q;

  assign m0_ack    = (state == ST_ACK) && (gnt == M_CPU);
  assign m1_ack    = (state == ST_ACK) && (gnt == M_DMA);
  assign m0_stall  = m0_req && !m0_ack;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: instance a (RD_LATENCY=1, MAX_LOCK=4)
// and instance b (RD_LATENCY=3) share stimulus; each phase checks one of them.
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic [31:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_wdata;
  logic        a_m0_ack, a_m0_stall, a_m1_ack, a_bus_we, a_bus_re;
  state_t      a_state;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_wdata;
  logic        b_m0_ack, b_m0_stall, b_m1_ack, b_bus_we, b_bus_re;
  state_t      b_state;

  int n_chk  = 0;
  int n_pass = 0;

  logic exp_m1 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  data_bus_arbiter #(.RD_LATENCY(1), .MAX_LOCK(4)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack), .m0_stall(a_m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack), .m1_lock(m1_lock),
    .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_we(a_bus_we),
    .bus_re(a_bus_re), .bus_rdata(bus_rdata), .dbg_state(a_state)
  );

  data_bus_arbiter #(.RD_LATENCY(3), .MAX_LOCK(16)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack), .m0_stall(b_m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack), .m1_lock(m1_lock),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_we(b_bus_we),
    .bus_re(b_bus_re), .bus_rdata(bus_rdata), .dbg_state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic do_reset();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    m1_lock = 1'b0;
    reset = 1'b0;
    nclk();
    nclk();
    reset = 1'b1;
  endtask

  initial begin
    // clock/reset and reset-state checks
    bus_rdata = 32'h0;
    do_reset();
    #1;
    chk("rst_state",  32'(a_state), 32'(ST_IDLE));
    chk("rst_busre",  32'(a_bus_re), 32'd0);
    chk("rst_buswe",  32'(a_bus_we), 32'd0);
    chk("rst_addr",   a_bus_addr, 32'h0);
    chk("rst_ack",    32'({a_m0_ack, a_m1_ack}), 32'd0);
    chk("rst_rdata",  a_m0_rdata, 32'h0);

    // m0 read, RD_LATENCY=1
    nclk();
    drive_m0(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_c0_stall", 32'(a_m0_stall), 32'd1);
    chk("rd_c0_re",    32'(a_bus_re), 32'd0);
    nclk();
    chk("rd_c1_re",    32'(a_bus_re), 32'd1);
    chk("rd_c1_addr",  a_bus_addr, 32'h0000_0010);
    chk("rd_c1_stall", 32'(a_m0_stall), 32'd1);
    chk("rd_c1_ack",   32'(a_m0_ack), 32'd0);
    nclk();
    chk("rd_c2_ack",   32'(a_m0_ack), 32'd1);
    chk("rd_c2_rdata", a_m0_rdata, 32'hDEAD_BEEF);
    chk("rd_c2_stall", 32'(a_m0_stall), 32'd0);
    chk("rd_c2_re",    32'(a_bus_re), 32'd0);
    nclk();
    chk("rd_c3_state", 32'(a_state), 32'(ST_IDLE));
    chk("rd_c3_ack",   32'(a_m0_ack), 32'd0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);

    // m0 write
    nclk();
    drive_m0(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    #1;
    chk("wr_c0_we",    32'(a_bus_we), 32'd0);
    nclk();
    chk("wr_c1_we",    32'(a_bus_we), 32'd1);
    chk("wr_c1_re",    32'(a_bus_re), 32'd0);
    chk("wr_c1_addr",  a_bus_addr, 32'h0000_0020);
    chk("wr_c1_wdata", a_bus_wdata, 32'h1234_5678);
    nclk();
    chk("wr_c2_ack",   32'(a_m0_ack), 32'd1);
    chk("wr_c2_we",    32'(a_bus_we), 32'd0);
    chk("wr_c2_m1ack", 32'(a_m1_ack), 32'd0);
    chk("wr_c2_m1rd",  a_m1_rdata, 32'h0);
    chk("wr_c2_m0rd",  a_m0_rdata, 32'hDEAD_BEEF);
    nclk();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);

    // simultaneous requests, round-robin 0,1,0,1 with no idle bubble
    do_reset();
    bus_rdata = 32'hAAAA_0000;
    drive_m0(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      nclk();
      chk($sformatf("rr%0d_access", i), 32'(a_state), 32'(ST_ACCESS));
      chk($sformatf("rr%0d_addr", i), a_bus_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
      nclk();
      chk($sformatf("rr%0d_m0ack", i), 32'(a_m0_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_m1ack", i), 32'(a_m1_ack), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    chk("rr_m1_rdata", a_m1_rdata, 32'hAAAA_0000);

    // lock: 4 m1 grants, one m0 grant, then m1 again
    do_reset();
    m1_lock = 1'b1;
    drive_m0(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 6; i++) begin
      nclk();
      chk($sformatf("lk%0d_addr", i), a_bus_addr, exp_m1[i] ? 32'h0000_0200 : 32'h0000_0100);
      nclk();
      chk($sformatf("lk%0d_m1ack", i), 32'(a_m1_ack), 32'(exp_m1[i]));
      chk($sformatf("lk%0d_m0ack", i), 32'(a_m0_ack), 32'(!exp_m1[i]));
    end

    // RD_LATENCY=3 m1 read on instance b, late bus_rdata value wins
    do_reset();
    drive_m1(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    bus_rdata = 32'h1111_1111;
    nclk();
    chk("lat_c1_state", 32'(b_state), 32'(ST_ACCESS));
    chk("lat_c1_re",    32'(b_bus_re), 32'd1);
    bus_rdata = 32'h2222_2222;
    nclk();
    chk("lat_c2_state", 32'(b_state), 32'(ST_WAIT));
    chk("lat_c2_re",    32'(b_bus_re), 32'd0);
    chk("lat_c2_addr",  b_bus_addr, 32'h0000_0300);
    chk("lat_c2_ack",   32'(b_m1_ack), 32'd0);
    bus_rdata = 32'h3333_3333;
    nclk();
    chk("lat_c3_state", 32'(b_state), 32'(ST_WAIT));
    chk("lat_c3_ack",   32'(b_m1_ack), 32'd0);
    bus_rdata = 32'hCAFE_F00D;
    nclk();
    chk("lat_c4_ack",   32'(b_m1_ack), 32'd1);
    chk("lat_c4_rdata", b_m1_rdata, 32'hCAFE_F00D);
    chk("lat_c4_m0ack", 32'(b_m0_ack), 32'd0);
    nclk();
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);

    // reset during WAIT, then a fresh m0 read completes
    do_reset();
    drive_m0(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    nclk();
    nclk();
    chk("mid_wait",     32'(b_state), 32'(ST_WAIT));
    reset = 1'b0;
    #1;
    chk("mid_state",    32'(b_state), 32'(ST_IDLE));
    chk("mid_addr",     b_bus_addr, 32'h0);
    chk("mid_ack",      32'({b_m0_ack, b_m1_ack}), 32'd0);
    nclk();
    chk("mid_hold_ack", 32'(b_m0_ack), 32'd0);
    nclk();
    reset = 1'b1;
    drive_m0(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    bus_rdata = 32'h5A5A_5A5A;
    nclk();
    chk("post_access",  32'(b_state), 32'(ST_ACCESS));
    chk("post_addr",    b_bus_addr, 32'h0000_0500);
    nclk();
    nclk();
    chk("post_no_ack",  32'(b_m0_ack), 32'd0);
    nclk();
    chk("post_ack",     32'(b_m0_ack), 32'd1);
    chk("post_rdata",   b_m0_rdata, 32'h5A5A_5A5A);
    nclk();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    nclk();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data-side bus (data memory port B, TimerCounter, GPIO behind Addr_Decoder) between two masters.
- Master 0 is the mips CPU data port; master 1 is a DMA / boot-loader master.
- Sits between the masters and the existing data_addr / write_data / data_we / read_data nets.
- Sequences every access as a fixed-length transaction and returns a one-cycle ack; the CPU is stalled until its ack.

Parameters:
RD_LATENCY, 1, clk cycles from bus address phase to valid bus_rdata (1..7)
MAX_LOCK, 16, max consecutive master-1 grants while m1_lock held before master 0 must be served

Ports:
clk  in  1  system clock (clk0)
reset  in  1  asynchronous, active-low reset
m0_req  in  1  CPU access request, held until m0_ack
m0_we  in  1  1=write, 0=read
m0_addr  in  32  byte address
m0_wdata  in  32  write data
m0_rdata  out  32  read data, valid when m0_ack
m0_ack  out  1  one-cycle completion pulse
m0_stall  out  1  m0_req & ~m0_ack, to CPU stall input
m1_req, m1_we, m1_addr[31:0], m1_wdata[31:0], m1_rdata[31:0], m1_ack  same as m0_*
m1_lock  in  1  master 1 requests back-to-back priority
bus_addr  out  32  to decoder / memory / peripherals
bus_wdata  out  32  write data
bus_we  out  1  write strobe, one cycle
bus_re  out  1  read strobe, one cycle
bus_rdata  in  32  muxed slave read data

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, last_grant=1 (master 0 wins first tie), lock_cnt=0.
- States: IDLE, ACCESS, WAIT, ACK. Registered grant gnt (0/1) and wait counter wcnt (3 bits).
- Arbitration (in IDLE and ACK): eligible = req high and not the master being acked this cycle. Only one eligible -> that one. Both eligible -> master 1 if m1_lock & lock_cnt<MAX_LOCK, else master != last_grant (round-robin).
- IDLE: eligible request -> ACCESS with gnt latched; else stay.
- ACCESS (exactly 1 cycle): bus_addr/bus_wdata from granted master; bus_we=we, bus_re=~we. Write -> ACK. Read: RD_LATENCY=1 -> ACK; else WAIT with wcnt=RD_LATENCY-1.
- WAIT: bus strobes 0, bus_addr held; wcnt decrements; at wcnt=1 -> ACK.
- bus_rdata captured into the granted master's rdata register on the edge leaving the last ACCESS/WAIT cycle of a read.
- ACK (1 cycle): ack of gnt=1; rdata valid (writes: rdata unchanged). last_grant<=gnt. Next state: ACCESS if another master is eligible (no idle bubble), else IDLE.
- Latency: write = 2 cycles req-to-ack; read = RD_LATENCY+1 cycles; plus any wait for the other master.
- lock_cnt: +1 on each master-1 grant while m1_lock=1 and m0_req=1; clears on any master-0 grant or m1_lock=0; saturates at MAX_LOCK.
- Masters hold req/we/addr/wdata until ack and drop req the cycle after ack. A req dropped mid-transaction does not abort; the access completes and ack still pulses.
- Non-granted master's ack/rdata unchanged; bus_* driven 0 in IDLE.
- Reset asserted mid-transaction: immediate return to IDLE, strobes and acks 0, no ack issued.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, ACCESS=1, WAIT=2, ACK=3) and master index constants M_CPU=0, M_DMA=1.
- One sub-module, rr_arb2: combinational two-way round-robin with lock override. Inputs: req[1:0], exclude[1:0], last, lock_win. Outputs: valid, grant.

Test Plan:
- Reset then m0 read 0x0000_0010, RD_LATENCY=1, bus_rdata=0xDEADBEEF -> bus_re high cycle 1, m0_ack cycle 2, m0_rdata=0xDEADBEEF, m0_stall high exactly 2 cycles.
- m0 write 0x0000_0020 data 0x12345678 -> bus_we one cycle with those values, m0_ack next cycle, m1 signals untouched.
- m0_req and m1_req raised same cycle after reset -> m0 granted first, m1 ACCESS directly in m0's ACK cycle+1, no IDLE bubble; repeat -> grants alternate 0,1,0,1.
- m1_lock=1, both requesting continuously, MAX_LOCK=4 -> 4 consecutive m1 grants then one m0 grant, then m1 again.
- RD_LATENCY=3, m1 read -> ACCESS, 2 WAIT cycles, ack on cycle 4; bus_rdata changed during WAIT ignored, value at last WAIT edge returned.
- reset pulsed low during WAIT -> outputs 0 asynchronously, no ack; after release a fresh m0 request completes normally.
